// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: opcode classes, op codes, compare result codes and FSM states for alu_pipe_core
package alu_pipe_pkg;
  localparam logic [1:0] CLS_ARITH = 2'b00, CLS_LOGIC = 2'b01, CLS_CMP = 2'b10, CLS_SHIFT = 2'b11;
  localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;
  localparam logic [1:0] OP_AND = 2'd0, OP_OR = 2'd1, OP_XOR = 2'd2, OP_NOR = 2'd3;
  localparam logic [1:0] OP_NOP = 2'd0, OP_EQ = 2'd1, OP_GT = 2'd2, OP_LT = 2'd3;
  localparam logic [1:0] OP_SRL = 2'd0, OP_SLL = 2'd1, OP_SRA = 2'd2, OP_ROL = 2'd3;
  localparam logic [1:0] CMP_EQ_RES = 2'd1, CMP_GT_RES = 2'd2, CMP_LT_RES = 2'd3;
  typedef enum logic [1:0] {IDLE, DIV, HOLD} state_t;
endpackage

// File: rtl/alu_div_iter.sv
// alu_div_iter: restoring unsigned divider, one quotient bit per cycle
module alu_div_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH);
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] quo, rem, dvs;
  logic [WIDTH:0] t;
  logic ge;
  // quotient/remainder are the post-step values, final while done is high
  assign t = {rem, quo[WIDTH-1]};
  assign ge = t >= {1'b0, dvs};
  assign quotient = {quo[WIDTH-2:0], ge};
  assign remainder = ge ? t[WIDTH-1:0] - dvs : t[WIDTH-1:0];
  assign done = busy && cnt == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy <= 1'b0;
      cnt <= '0;
      quo <= '0;
      rem <= '0;
      dvs <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= CW'(WIDTH - 1);
      quo <= a;
      rem <= '0;
      dvs <= b;
    end else if (busy) begin
      quo <= quotient;
      rem <= remainder;
      cnt <= cnt - CW'(1);
      busy <= cnt != '0;
    end
endmodule

// File: rtl/alu_pipe_core.sv
// alu_pipe_core: valid/ready ALU with registered result bus, flags and iterative divide
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A_IN,
  input  logic [WIDTH-1:0] B_IN,
  input  logic [3:0]       ALU_FUN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic [WIDTH-1:0] ALU_OUT_HI,
  output logic             Carry_out,
  output logic             ZERO_FLAG,
  output logic             OVF_FLAG,
  output logic             DIV_BY_ZERO,
  output logic [3:0]       UNIT_FLAG
);
  state_t state, state_nx;
  logic accept, div_start, div_busy, div_done, hs;
  logic [WIDTH-1:0] div_q, div_r, sra, r_lo, r_hi;
  logic [1:0] cls, op;
  logic [SHW-1:0] shamt;
  logic [WIDTH:0] sum, dif;
  logic [2*WIDTH-1:0] prod;
  logic r_c, r_ovf, r_dbz;
  assign cls = ALU_FUN[3:2];
  assign op = ALU_FUN[1:0];
  assign shamt = B_IN[SHW-1:0];
  assign IN_READY = state == IDLE && !div_busy && (!OUT_VALID || OUT_READY);
  assign accept = IN_VALID && IN_READY;
  assign hs = OUT_VALID && OUT_READY;
  assign div_start = accept && cls == CLS_ARITH && op == OP_DIV && B_IN != '0;
  assign sum = {1'b0, A_IN} + {1'b0, B_IN};
  assign dif = {1'b0, A_IN} - {1'b0, B_IN};
  assign prod = {{WIDTH{1'b0}}, A_IN} * {{WIDTH{1'b0}}, B_IN};
  assign sra = $signed(A_IN) >>> shamt;
  alu_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk(CLK), .rst(RST), .start(div_start), .a(A_IN), .b(B_IN),
    .busy(div_busy), .done(div_done), .quotient(div_q), .remainder(div_r)
  );
  always_comb begin
    r_lo = '0;
    r_hi = '0;
    r_c = 1'b0;
    r_ovf = 1'b0;
    r_dbz = 1'b0;
    case (cls)
      CLS_ARITH:
        case (op)
          OP_ADD: begin
            r_lo = sum[WIDTH-1:0];
            r_c = sum[WIDTH];
            r_ovf = A_IN[WIDTH-1] == B_IN[WIDTH-1] && sum[WIDTH-1] != A_IN[WIDTH-1];
          end
          OP_SUB: begin
            r_lo = dif[WIDTH-1:0];
            r_c = dif[WIDTH];
            r_ovf = A_IN[WIDTH-1] != B_IN[WIDTH-1] && dif[WIDTH-1] != A_IN[WIDTH-1];
          end
          OP_MUL: begin
            r_lo = prod[WIDTH-1:0];
            r_hi = prod[2*WIDTH-1:WIDTH];
            r_ovf = prod[2*WIDTH-1:WIDTH] != '0;
          end
          default: begin
            // only the B==0 divide completes here; B!=0 goes to the iterative unit
            r_lo = '1;
            r_hi = A_IN;
            r_dbz = 1'b1;
          end
        endcase
      CLS_LOGIC: r_lo = op == OP_AND ? A_IN & B_IN : op == OP_OR ? A_IN | B_IN :
                        op == OP_XOR ? A_IN ^ B_IN : ~(A_IN | B_IN);
      CLS_CMP: r_lo = op == OP_EQ && A_IN == B_IN ? WIDTH'(CMP_EQ_RES) :
                      op == OP_GT && A_IN > B_IN ? WIDTH'(CMP_GT_RES) :
                      op == OP_LT && A_IN < B_IN ? WIDTH'(CMP_LT_RES) : '0;
      default: r_lo = op == OP_SRL ? A_IN >> shamt : op == OP_SLL ? A_IN << shamt :
                      op == OP_SRA ? sra : (A_IN << shamt) | (A_IN >> (WIDTH - int'(shamt)));
    endcase
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (div_start) state_nx = DIV;
      DIV: if (div_done) state_nx = HOLD;
      HOLD: if (hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      OUT_VALID <= 1'b0;
      ALU_OUT <= '0;
      ALU_OUT_HI <= '0;
      Carry_out <= 1'b0;
      ZERO_FLAG <= 1'b0;
      OVF_FLAG <= 1'b0;
      DIV_BY_ZERO <= 1'b0;
      UNIT_FLAG <= '0;
    end else if (accept && !div_start) begin
      OUT_VALID <= 1'b1;
      ALU_OUT <= r_lo;
      ALU_OUT_HI <= r_hi;
      Carry_out <= r_c;
      ZERO_FLAG <= r_lo == '0;
      OVF_FLAG <= r_ovf;
      DIV_BY_ZERO <= r_dbz;
      UNIT_FLAG <= 4'b0001 << cls;
    end else if (div_done) begin
      OUT_VALID <= 1'b1;
      ALU_OUT <= div_q;
      ALU_OUT_HI <= div_r;
      Carry_out <= 1'b0;
      ZERO_FLAG <= div_q == '0;
      OVF_FLAG <= 1'b0;
      DIV_BY_ZERO <= 1'b0;
      UNIT_FLAG <= 4'b0001;
    end else if (hs) OUT_VALID <= 1'b0;
endmodule
